// File: rtl/regfile_wr_decode.sv
// Register file for the pipelined LEGv8 datapath.
// The write side decodes wr_addr to a one-hot enable with a tree of 2:4 decoders.
// Each read port is a 4:1/2:1 mux tree with a same-cycle write bypass and a hardwired XZR.
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : write-back port
//   rd_addr_a/rd_data_a   : read port A (combinational)
//   rd_addr_b/rd_data_b   : read port B (combinational)
//   wr_onehot             : registered decoded write enable from the last edge

// 2:4 decoder with enable.
module dec2to4 (
    input  logic       en,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    assign y[0] = en & ~sel[1] & ~sel[0];
    assign y[1] = en & ~sel[1] &  sel[0];
    assign y[2] = en &  sel[1] & ~sel[0];
    assign y[3] = en &  sel[1] &  sel[0];
endmodule

// 2:1 word mux.
module mux2 #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

// 4:1 word mux.
module mux4 #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    input  logic [1:0]   sel,
    output logic [W-1:0] y
);
    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            default: y = d3;
        endcase
    end
endmodule

// Binary-to-one-hot decoder built from 2:4 stages, MSB chunk first.
// An odd leftover MSB is split by a single 1:2 root stage.
module wr_dec_tree #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     en,
    input  logic [ADDR_W-1:0]        addr,
    output logic [(2**ADDR_W)-1:0]   y
);
    localparam int unsigned ODD    = ADDR_W % 2;
    localparam int unsigned NSTAGE = ADDR_W / 2;

    // Offset of level l inside the flat node vector; level l holds 2^(ODD+2l) enables.
    function automatic int unsigned lvl_off(input int unsigned l);
        int unsigned o;
        o = 0;
        for (int unsigned j = 0; j < l; j++) o += (32'd1 << (ODD + 2 * j));
        return o;
    endfunction

    localparam int unsigned TOT = lvl_off(NSTAGE + 1);

    logic [TOT-1:0] node;

    if (ODD != 0) begin : g_root_odd
        assign node[0] = en & ~addr[ADDR_W-1];
        assign node[1] = en &  addr[ADDR_W-1];
    end else begin : g_root_even
        assign node[0] = en;
    end

    for (genvar l = 1; l <= NSTAGE; l++) begin : g_lvl
        localparam int unsigned NPAR = 32'd1 << (ODD + 2 * (l - 1));
        localparam int unsigned POFF = lvl_off(l - 1);
        localparam int unsigned COFF = lvl_off(l);
        localparam int unsigned LSB  = ADDR_W - ODD - 2 * l;
        for (genvar p = 0; p < NPAR; p++) begin : g_dec
            dec2to4 u_dec (
                .en  (node[POFF + p]),
                .sel (addr[LSB +: 2]),
                .y   (node[COFF + 4 * p +: 4])
            );
        end
    end

    assign y = node[lvl_off(NSTAGE) +: (2**ADDR_W)];
endmodule

// Read mux tree: 4:1 levels consume select bits from the LSB, a final 2:1 takes an odd MSB.
module rd_mux_tree #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] words,
    input  logic [ADDR_W-1:0]                  sel,
    output logic [DATA_W-1:0]                  y
);
    localparam int unsigned NREGS  = 2**ADDR_W;
    localparam int unsigned ODD    = ADDR_W % 2;
    localparam int unsigned NSTAGE = ADDR_W / 2;

    // Offset of level m in the flat word array; level m holds NREGS/4^m words.
    function automatic int unsigned moff(input int unsigned m);
        int unsigned o;
        o = 0;
        for (int unsigned j = 0; j < m; j++) o += (NREGS >> (2 * j));
        return o;
    endfunction

    localparam int unsigned MTOT = moff(NSTAGE + 1);

    logic [MTOT-1:0][DATA_W-1:0] mnode;

    assign mnode[NREGS-1:0] = words;

    for (genvar m = 1; m <= NSTAGE; m++) begin : g_lvl
        localparam int unsigned NOUT = NREGS >> (2 * m);
        localparam int unsigned POFF = moff(m - 1);
        localparam int unsigned COFF = moff(m);
        for (genvar q = 0; q < NOUT; q++) begin : g_mux
            mux4 #(.W(DATA_W)) u_mux (
                .d0  (mnode[POFF + 4 * q + 0]),
                .d1  (mnode[POFF + 4 * q + 1]),
                .d2  (mnode[POFF + 4 * q + 2]),
                .d3  (mnode[POFF + 4 * q + 3]),
                .sel (sel[2 * (m - 1) +: 2]),
                .y   (mnode[COFF + q])
            );
        end
    end

    if (ODD != 0) begin : g_top_odd
        mux2 #(.W(DATA_W)) u_mux (
            .d0  (mnode[moff(NSTAGE) + 0]),
            .d1  (mnode[moff(NSTAGE) + 1]),
            .sel (sel[ADDR_W-1]),
            .y   (y)
        );
    end else begin : g_top_even
        assign y = mnode[moff(NSTAGE)];
    end
endmodule

module regfile_wr_decode #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [ADDR_W-1:0]      rd_addr_a,
    input  logic [ADDR_W-1:0]      rd_addr_b,
    output logic [DATA_W-1:0]      rd_data_a,
    output logic [DATA_W-1:0]      rd_data_b,
    output logic [(2**ADDR_W)-1:0] wr_onehot
);
    localparam int unsigned NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(NREGS - 1);
    localparam logic [NREGS-1:0]  ZERO_MASK = {1'b1, {(NREGS-1){1'b0}}};

    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NREGS-1:0]             onehot_q;
    logic [NREGS-1:0]             dec_raw, dec;
    logic [DATA_W-1:0]            mux_a, mux_b;

    // Write address decode; XZR never gets an enable.
    wr_dec_tree #(.ADDR_W(ADDR_W)) u_dec (
        .en   (wr_en),
        .addr (wr_addr),
        .y    (dec_raw)
    );
    assign dec = dec_raw & ~ZERO_MASK;

    // One-hot enable steers wr_data into the selected register only.
    always_comb begin
        regs_d = regs_q;
        for (int k = 0; k < int'(NREGS); k++) begin
            if (dec[k]) regs_d[k] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q   <= '0;
            onehot_q <= '0;
        end else begin
            regs_q   <= regs_d;
            onehot_q <= dec;
        end
    end

    assign wr_onehot = onehot_q;

    rd_mux_tree #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_a (
        .words (regs_q),
        .sel   (rd_addr_a),
        .y     (mux_a)
    );

    rd_mux_tree #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_b (
        .words (regs_q),
        .sel   (rd_addr_b),
        .y     (mux_b)
    );

    // XZR beats bypass beats storage; bypass is suppressed while reset is high.
    always_comb begin
        rd_data_a = mux_a;
        if (wr_en && !reset && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (rd_addr_a == ZERO_IDX) rd_data_a = '0;

        rd_data_b = mux_b;
        if (wr_en && !reset && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
        if (rd_addr_b == ZERO_IDX) rd_data_b = '0;
    end
endmodule

// File: tb/tb_regfile_wr_decode.sv
// Scoreboard bench for regfile_wr_decode: the driver applies one vector per cycle
// and queues its hand-computed expectation; the monitor checks at the falling edge.
module tb_regfile_wr_decode;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [NREGS-1:0]  wr_onehot;

    regfile_wr_decode #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_onehot (wr_onehot)
    );

    typedef struct {
        logic [DATA_W-1:0] exp_a;
        logic [DATA_W-1:0] exp_b;
        logic [NREGS-1:0]  exp_oh;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one vector just after the rising edge and queue its expectation.
    task automatic step(input logic rst, input logic we, input int wa, input logic [DATA_W-1:0] wd,
                        input int ra, input int rb,
                        input logic [DATA_W-1:0] ea, input logic [DATA_W-1:0] eb,
                        input logic [NREGS-1:0] eoh, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst;
        wr_en     = we;
        wr_addr   = ADDR_W'(wa);
        wr_data   = wd;
        rd_addr_a = ADDR_W'(ra);
        rd_addr_b = ADDR_W'(rb);
        e.exp_a   = ea;
        e.exp_b   = eb;
        e.exp_oh  = eoh;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (rd_data_a !== e.exp_a) begin
                errors++;
                $display("FAIL %s rd_data_a: got %h expected %h", nm, rd_data_a, e.exp_a);
            end
            checks++;
            if (rd_data_b !== e.exp_b) begin
                errors++;
                $display("FAIL %s rd_data_b: got %h expected %h", nm, rd_data_b, e.exp_b);
            end
            checks++;
            if (wr_onehot !== e.exp_oh) begin
                errors++;
                $display("FAIL %s wr_onehot: got %h expected %h", nm, wr_onehot, e.exp_oh);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;

        // First reset edge clears storage; reads in the following reset cycle are 0.
        @(posedge clk);
        step(1, 0, 0, 64'h0, 0, 31, 64'h0, 64'h0, 32'h0, "reset_hold");

        // All addresses read 0 on both ports.
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 64'h0, i, 31 - i, 64'h0, 64'h0, 32'h0, "reset_read");

        // X5 write: bypass this cycle, storage next cycle.
        step(0, 1, 5, 64'hDEAD_BEEF_0123_4567, 5, 0,
             64'hDEAD_BEEF_0123_4567, 64'h0, 32'h0, "x5_bypass");
        step(0, 0, 0, 64'h0, 5, 5,
             64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 32'h0000_0020, "x5_stored");

        // XZR write is discarded and always reads 0.
        step(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 64'h0, 64'h0, 32'h0, "xzr_write");
        step(0, 0, 0, 64'h0, 31, 31, 64'h0, 64'h0, 32'h0, "xzr_after");

        // X0..X30 <= 1..31; port A bypasses, port B reads the previous register from storage.
        for (int i = 0; i < 31; i++)
            step(0, 1, i, 64'(i + 1), i, (i == 0) ? 31 : i - 1,
                 64'(i + 1), (i == 0) ? 64'h0 : 64'(i),
                 (i == 0) ? 32'h0 : (32'h1 << (i - 1)), "fill");
        step(0, 0, 0, 64'h0, 0, 30, 64'd1, 64'd31, 32'h4000_0000, "pair_0_30");
        step(0, 0, 0, 64'h0, 15, 16, 64'd16, 64'd17, 32'h0, "pair_15_16");
        step(0, 0, 0, 64'h0, 29, 1, 64'd30, 64'd2, 32'h0, "pair_29_1");

        // Back-to-back writes to X9: each visible by bypass, last one wins.
        step(0, 1, 9, 64'hA1, 9, 10, 64'hA1, 64'd11, 32'h0, "b2b_first");
        step(0, 1, 9, 64'hB2, 9, 9, 64'hB2, 64'hB2, 32'h0000_0200, "b2b_second");
        step(0, 0, 0, 64'h0, 9, 8, 64'hB2, 64'd9, 32'h0000_0200, "b2b_stored");

        // wr_en low: no write, no bypass.
        step(0, 0, 7, 64'h55, 7, 7, 64'd8, 64'd8, 32'h0, "noen_x7");
        step(0, 0, 0, 64'h0, 7, 6, 64'd8, 64'd7, 32'h0, "noen_after");

        // One-edge reset with a write pending: no bypass, write lost, storage cleared.
        step(1, 1, 3, 64'h99, 3, 4, 64'd4, 64'd5, 32'h0, "rst_edge");
        step(0, 0, 0, 64'h0, 3, 5, 64'h0, 64'h0, 32'h0, "rst_after");

        // Two-edge reset: after the first edge address 3 reads 0 while reset is still high.
        step(0, 1, 3, 64'h77, 3, 3, 64'h77, 64'h77, 32'h0, "x3_write");
        step(1, 1, 3, 64'h99, 3, 3, 64'h77, 64'h77, 32'h0000_0008, "rst2_first");
        step(1, 1, 3, 64'h99, 3, 3, 64'h0, 64'h0, 32'h0, "rst2_second");
        step(0, 0, 0, 64'h0, 3, 9, 64'h0, 64'h0, 32'h0, "rst2_after");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
